signed_max_unpool: RTL and testbench

- Inverse of the max-pooling path: accepts one pooled signed value plus its argmax index and expands it back into a full pooling window.
- The window is emitted as a stream of beats. The beat at the recorded index carries the value; every other beat carries zero.
- Sits on the backward/upsampling datapath, downstream of the pooled-activation buffer and upstream of the window writer.
- Valid/ready handshake on both sides; supports back-to-back windows with no bubble.

---
 rtl/signed_max_unpool_if.sv | 26 ++
 rtl/signed_max_unpool.sv | 105 ++++++++++
 tb/tb_signed_max_unpool.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/signed_max_unpool_if.sv
// Handshake bundle for the max-unpool block.
// The input side carries the pooled value and its argmax index; the output side carries the expanded window beats.
interface signed_max_unpool_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_WIDTH  = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic [IDX_WIDTH-1:0]         in_idx;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_last;

  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/signed_max_unpool.sv
// Signed max-unpool: expands one pooled value plus its argmax index into a window of beats.
// Every beat is zero except the beat at the index. Back-to-back windows are supported with no bubble.
module signed_max_unpool #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_POOL   = 4,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_WIDTH-1:0]  cfg_pool_size,
  signed_max_unpool_if.slave    bus,
  output logic                  err_idx
);

  localparam int unsigned CMP_W = (IDX_WIDTH > CNT_WIDTH) ? IDX_WIDTH : CNT_WIDTH;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_e;

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] val_q, val_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;
  logic [CNT_WIDTH-1:0]         size_q, size_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         err_q, err_d;

  logic [CNT_WIDTH-1:0]         cfg_eff;
  logic                         is_last;
  logic                         accept;
  logic                         beat;

  // Window size is clamped into 1..MAX_POOL at the moment an element is accepted.
  always_comb begin
    cfg_eff = cfg_pool_size;
    if (cfg_pool_size == '0) begin
      cfg_eff = CNT_WIDTH'(1);
    end else if (cfg_pool_size > CNT_WIDTH'(MAX_POOL)) begin
      cfg_eff = CNT_WIDTH'(MAX_POOL);
    end
  end

  // All out_* signals decode from registers only; in_ready may follow out_ready so the next window can load on the last-beat handshake.
  always_comb begin
    is_last       = (state_q == EXPAND) && (cnt_q == (size_q - CNT_WIDTH'(1)));
    bus.out_valid = (state_q == EXPAND);
    bus.out_last  = is_last;
    bus.out_data  = '0;
    if ((state_q == EXPAND) && (CMP_W'(cnt_q) == CMP_W'(idx_q))) begin
      bus.out_data = val_q;
    end
    bus.in_ready  = (state_q == IDLE) || (bus.out_ready && is_last);
    accept        = bus.in_valid && bus.in_ready;
    beat          = bus.out_valid && bus.out_ready;
  end

  assign err_idx = err_q;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    idx_d   = idx_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (beat && !is_last) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    if (accept) begin
      val_d   = bus.in_data;
      idx_d   = bus.in_idx;
      size_d  = cfg_eff;
      cnt_d   = '0;
      state_d = EXPAND;
      if (CMP_W'(bus.in_idx) >= CMP_W'(cfg_eff)) begin
        err_d = 1'b1;
      end
    end else if (beat && is_last) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      idx_q   <= '0;
      size_q  <= CNT_WIDTH'(1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_signed_max_unpool.sv
// Self-checking bench for signed_max_unpool.
// It applies table vectors, hand-built multi-cycle sequences, and random traffic checked against a window-queue model.
module tb_signed_max_unpool;
  localparam int unsigned DW = 8;
  localparam int unsigned MP = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] cfg;
  logic          err_idx;

  signed_max_unpool_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  signed_max_unpool #(
    .DATA_WIDTH(DW),
    .MAX_POOL  (MP),
    .IDX_WIDTH (IW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_pool_size(cfg),
    .bus          (bus),
    .err_idx      (err_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [CW-1:0]        cfg;
    logic signed [DW-1:0] data;
    logic [IW-1:0]        idx;
    int unsigned          nb;
    logic signed [DW-1:0] exp [4];
    logic                 err;
  } vec_t;

  function automatic vec_t mk(input int c, input int d, input int i, input int nb,
                              input int e0, input int e1, input int e2, input int e3,
                              input int err);
    vec_t v;
    v.cfg    = CW'(c);
    v.data   = DW'(d);
    v.idx    = IW'(i);
    v.nb     = nb;
    v.exp[0] = DW'(e0);
    v.exp[1] = DW'(e1);
    v.exp[2] = DW'(e2);
    v.exp[3] = DW'(e3);
    v.err    = err[0];
    return v;
  endfunction

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_idx    = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_data", 32'(bus.out_data), 0);
    chk("rst out_last", 32'(bus.out_last), 0);
    chk("rst err_idx", 32'(err_idx), 0);
    chk("rst in_ready", 32'(bus.in_ready), 1);
  endtask

  // Random-phase reference model: each accepted element becomes a queue of expected beats.
  typedef struct {
    logic signed [DW-1:0] d;
    logic                 l;
  } beat_t;

  beat_t q[$];
  logic  err_m;
  logic  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic        rdy_m;
      int unsigned p;
      beat_t       b;
      rdy_m = (q.size() == 0) || (bus.out_ready && (q.size() == 1));
      chk("rnd out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("rnd in_ready", 32'(bus.in_ready), 32'(rdy_m));
      chk("rnd err_idx", 32'(err_idx), 32'(err_m));
      if (bus.out_valid && (q.size() != 0)) begin
        chk("rnd out_data", 32'(bus.out_data), 32'(q[0].d));
        chk("rnd out_last", 32'(bus.out_last), 32'(q[0].l));
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && rdy_m) begin
        if (cfg == 0) p = 1;
        else if (int'(cfg) > int'(MP)) p = MP;
        else p = int'(cfg);
        for (int unsigned k = 0; k < p; k++) begin
          b.d = (k == int'(bus.in_idx)) ? bus.in_data : '0;
          b.l = (k == p - 1);
          q.push_back(b);
        end
        if (int'(bus.in_idx) >= int'(p)) err_m = 1'b1;
      end
    end
  end

  vec_t tv [8];

  initial begin
    logic signed [DW-1:0] eb [12];
    logic signed [DW-1:0] bd [3];
    logic [IW-1:0]        bi [3];
    logic                 rdy [5];
    logic signed [DW-1:0] bpd [5];
    int                   ei;
    logic                 acc;

    cfg = '0;
    tv[0] = mk(4,   -5, 2, 4,    0,  0,  -5,  0, 0);
    tv[1] = mk(0,    9, 0, 1,    9,  0,   0,  0, 0);
    tv[2] = mk(6,   33, 3, 4,    0,  0,   0, 33, 0);
    tv[3] = mk(2,   44, 3, 2,    0,  0,   0,  0, 1);
    tv[4] = mk(1, -128, 0, 1, -128,  0,   0,  0, 0);
    tv[5] = mk(3,  100, 2, 3,    0,  0, 100,  0, 0);
    tv[6] = mk(7,   -1, 1, 4,    0, -1,   0,  0, 0);
    tv[7] = mk(1,    5, 1, 1,    0,  0,   0,  0, 1);

    for (int t = 0; t < 8; t++) begin
      do_reset();
      cfg           = tv[t].cfg;
      bus.in_data   = tv[t].data;
      bus.in_idx    = tv[t].idx;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int unsigned k = 0; k < tv[t].nb; k++) begin
        @(negedge clk);
        chk($sformatf("tv%0d.%0d valid", t, k), 32'(bus.out_valid), 1);
        chk($sformatf("tv%0d.%0d data", t, k), 32'(bus.out_data), 32'(tv[t].exp[k]));
        chk($sformatf("tv%0d.%0d last", t, k), 32'(bus.out_last), 32'(k == tv[t].nb - 1));
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk($sformatf("tv%0d end valid", t), 32'(bus.out_valid), 0);
      chk($sformatf("tv%0d err", t), 32'(err_idx), 32'(tv[t].err));
    end

    // Back-to-back windows with in_valid and out_ready held high.
    do_reset();
    bd[0] = 8'sd7;   bi[0] = 2'd0;
    bd[1] = -8'sd128; bi[1] = 2'd3;
    bd[2] = 8'sd1;   bi[2] = 2'd1;
    eb = '{8'sd7, 0, 0, 0, 0, 0, 0, -8'sd128, 0, 8'sd1, 0, 0};
    cfg           = 3'd4;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = bd[0];
    bus.in_idx    = bi[0];
    ei = 0;
    @(posedge clk);
    #1;
    ei = 1;
    bus.in_data = bd[1];
    bus.in_idx  = bi[1];
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d valid", k), 32'(bus.out_valid), 1);
      chk($sformatf("b2b%0d data", k), 32'(bus.out_data), 32'(eb[k]));
      chk($sformatf("b2b%0d last", k), 32'(bus.out_last), 32'(k % 4 == 3));
      chk($sformatf("b2b%0d in_ready", k), 32'(bus.in_ready), 32'(k % 4 == 3));
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ei++;
        if (ei < 3) begin
          bus.in_data = bd[ei];
          bus.in_idx  = bi[ei];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("b2b end valid", 32'(bus.out_valid), 0);

    // Backpressure stalls, with a mid-window size change that must be ignored.
    do_reset();
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bpd = '{0, 8'sd25, 8'sd25, 8'sd25, 0};
    cfg           = 3'd3;
    bus.in_data   = 8'sd25;
    bus.in_idx    = 2'd1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cfg          = 3'd2;
    for (int k = 0; k < 5; k++) begin
      bus.out_ready = rdy[k];
      @(negedge clk);
      chk($sformatf("bp%0d valid", k), 32'(bus.out_valid), 1);
      chk($sformatf("bp%0d data", k), 32'(bus.out_data), 32'(bpd[k]));
      chk($sformatf("bp%0d last", k), 32'(bus.out_last), 32'(k == 4));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bp end valid", 32'(bus.out_valid), 0);

    // A bad index sets a sticky error; a reset mid-window clears it and drops the window.
    do_reset();
    cfg           = 3'd2;
    bus.in_data   = 8'sd5;
    bus.in_idx    = 2'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("bad%0d data", k), 32'(bus.out_data), 0);
      chk($sformatf("bad%0d last", k), 32'(bus.out_last), 32'(k == 1));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bad err set", 32'(err_idx), 1);
    @(posedge clk);
    #1;
    cfg          = 3'd4;
    bus.in_data  = 8'sd12;
    bus.in_idx   = 2'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("pre%0d data", k), 32'(bus.out_data), 0);
      chk($sformatf("pre%0d err sticky", k), 32'(err_idx), 1);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid rst valid", 32'(bus.out_valid), 0);
    chk("mid rst err", 32'(err_idx), 0);
    chk("mid rst in_ready", 32'(bus.in_ready), 1);
    chk("mid rst last", 32'(bus.out_last), 0);
    @(posedge clk);
    #1;
    bus.in_data  = 8'sd3;
    bus.in_idx   = 2'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post%0d valid", k), 32'(bus.out_valid), 1);
      chk($sformatf("post%0d data", k), 32'(bus.out_data), (k == 0) ? 32'd3 : 32'd0);
      chk($sformatf("post%0d last", k), 32'(bus.out_last), 32'(k == 3));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("post end valid", 32'(bus.out_valid), 0);

    // Random traffic against the queue model.
    do_reset();
    q.delete();
    err_m  = 1'b0;
    mon_en = 1'b1;
    repeat (3000) begin
      @(posedge clk);
      #1;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = DW'($urandom);
      bus.in_idx    = IW'($urandom);
      cfg           = CW'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
